// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcode map, one-hot state
// encoding and the decoded instruction flag bundle.
package cpu_ctrl_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_STA = 4'h0;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h1;
    localparam logic [OPC_W-1:0] OP_STP = 4'h2;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h3;
    localparam logic [OPC_W-1:0] OP_JMS = 4'h4;
    localparam logic [OPC_W-1:0] OP_BBL = 4'h5;
    localparam logic [OPC_W-1:0] OP_JEQ = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMC = 4'h7;
    localparam logic [OPC_W-1:0] OP_MUL = 4'hD;
    localparam logic [OPC_W-1:0] OP_LDR = 4'hE;

    localparam int FETCH_BIT = 0;
    localparam int EXEC1_BIT = 1;
    localparam int EXEC2_BIT = 2;
    localparam int EXEC3_BIT = 3;
    localparam int HALT_BIT  = 4;
    localparam int FAULT_BIT = 5;

    typedef enum logic [5:0] {
        S_FETCH = 6'b000001,
        S_EXEC1 = 6'b000010,
        S_EXEC2 = 6'b000100,
        S_EXEC3 = 6'b001000,
        S_HALT  = 6'b010000,
        S_FAULT = 6'b100000
    } state_t;

    typedef struct packed {
        logic sta;
        logic jmp;
        logic stp;
        logic lda;
        logic jms;
        logic bbl;
        logic jeq;
        logic jmc;
        logic mul;
        logic ldr;
    } instr_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: the top four instruction bits select one flag;
// unknown opcodes decode to all-zero flags (NOP).
module op_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] inst,
    output instr_t         flags
);

    logic [OPC_W-1:0] opcode;

    assign opcode = inst[OPW-1:OPW-OPC_W];

    always_comb begin
        flags = '0;
        case (opcode)
            OP_STA:  flags.sta = 1'b1;
            OP_JMP:  flags.jmp = 1'b1;
            OP_STP:  flags.stp = 1'b1;
            OP_LDA:  flags.lda = 1'b1;
            OP_JMS:  flags.jms = 1'b1;
            OP_BBL:  flags.bbl = 1'b1;
            OP_JEQ:  flags.jeq = 1'b1;
            OP_JMC:  flags.jmc = 1'b1;
            OP_MUL:  flags.mul = 1'b1;
            OP_LDR:  flags.ldr = 1'b1;
            default: flags = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// CPU control unit: one-hot instruction sequencer with return-stack depth
// tracking, multiplier handshake with timeout, STP halt and sticky fault.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int STACK_DEPTH = 4,
    parameter int MUL_TIMEOUT = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    input  logic [OPW-1:0]                     inst,
    input  logic                               eq,
    input  logic                               carry,
    input  logic                               mul_done,
    output logic [5:0]                         state,
    output logic [1:0]                         jump_mux,
    output logic                               WrEn,
    output logic                               pc_load,
    output logic                               pc_inc,
    output logic                               acc_load,
    output logic                               e,
    output logic                               m,
    output logic                               push,
    output logic                               pop,
    output logic                               data_mux,
    output logic                               load_mux,
    output logic                               mul_start,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               fault
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int TW  = $clog2(MUL_TIMEOUT + 1);

    state_t         state_q;
    state_t         state_d;
    logic [SPW-1:0] sp_q;
    logic [TW-1:0]  timer_q;
    instr_t         ins;
    logic           stack_room;
    logic           stack_any;

    op_decoder #(.OPW(OPW)) u_dec (
        .inst  (inst),
        .flags (ins)
    );

    assign e          = ins.lda | ins.ldr | ins.mul;
    assign m          = ins.mul;
    assign data_mux   = ins.ldr;
    assign load_mux   = ins.bbl;
    assign jump_mux   = {ins.jmc, ins.bbl};
    assign stack_room = sp_q < SPW'(STACK_DEPTH);
    assign stack_any  = sp_q != '0;
    assign state      = state_q;
    assign sp         = sp_q;
    assign fault      = state_q[FAULT_BIT];

    // Timer holds the number of EXEC2 cycles already spent waiting on the multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            sp_q    <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (push)
                sp_q <= sp_q + SPW'(1);
            else if (pop)
                sp_q <= sp_q - SPW'(1);
            if (state_q == S_EXEC2 && state_d == S_EXEC2)
                timer_q <= timer_q + TW'(1);
            else
                timer_q <= '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        WrEn      = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        acc_load  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            S_FETCH: begin
                pc_inc  = 1'b1;
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                WrEn = ins.sta;
                if (ins.stp)
                    state_d = S_HALT;
                else if ((ins.jms && !stack_room) || (ins.bbl && !stack_any))
                    state_d = S_FAULT;
                else if (e)
                    state_d = S_EXEC2;
                else begin
                    pc_load = ins.jmp | ins.jms | ins.bbl | (ins.jeq & ~eq) | (ins.jmc & carry);
                    push    = ins.jms;
                    pop     = ins.bbl;
                    pc_inc  = ~pc_load;
                    state_d = S_FETCH;
                end
            end
            S_EXEC2: begin
                // A completion on the last allowed cycle still beats the timeout.
                if (ins.mul) begin
                    mul_start = (timer_q == '0);
                    if (mul_done)
                        state_d = S_EXEC3;
                    else if (timer_q == TW'(MUL_TIMEOUT - 1))
                        state_d = S_FAULT;
                end else begin
                    acc_load = ins.lda | ins.ldr;
                    pc_inc   = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC3: begin
                pc_inc  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a cycle-level reference model queues
// expected outputs per cycle and an independent monitor compares at negedge.
module tb_control_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [6:0] st;
        logic [6:0] strobes;
        logic [5:0] dec;
        logic [2:0] sp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, run, eq, carry, mul_done;
    logic [3:0] inst;
    logic [5:0] state;
    logic [1:0] jump_mux;
    logic       WrEn, pc_load, pc_inc, acc_load, e, m, push, pop;
    logic       data_mux, load_mux, mul_start, fault;
    logic [2:0] sp;

    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    exp_t exp_q[$];

    // Reference model: phase 0..5 = FETCH, EXEC1, EXEC2, EXEC3, HALT, FAULT
    int m_phase = 0;
    int m_sp    = 0;
    int m_wait  = 0;

    control_sequencer #(.OPW(4), .STACK_DEPTH(DEPTH), .MUL_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .inst(inst), .eq(eq), .carry(carry),
        .mul_done(mul_done), .state(state), .jump_mux(jump_mux), .WrEn(WrEn),
        .pc_load(pc_load), .pc_inc(pc_inc), .acc_load(acc_load), .e(e), .m(m),
        .push(push), .pop(pop), .data_mux(data_mux), .load_mux(load_mux),
        .mul_start(mul_start), .sp(sp), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input bit rst, input bit run_i, input logic [3:0] op,
                                 input bit eq_i, input bit carry_i, input bit done_i);
        bit   wr, ld, inc, acc, ps, pp, ms;
        bit   is_ext;
        int   nxt;
        exp_t x;
        reset = rst; run = run_i; inst = op; eq = eq_i; carry = carry_i; mul_done = done_i;
        {wr, ld, inc, acc, ps, pp, ms} = '0;
        is_ext = (op == 4'h3) || (op == 4'hD) || (op == 4'hE);
        nxt = m_phase;
        case (m_phase)
            0: begin inc = 1; nxt = 1; end
            1: begin
                nxt = 0;
                if (op == 4'h2) nxt = 4;
                else if (op == 4'h4 && m_sp == DEPTH) nxt = 5;
                else if (op == 4'h5 && m_sp == 0) nxt = 5;
                else if (is_ext) nxt = 2;
                else begin
                    wr = (op == 4'h0);
                    case (op)
                        4'h1: ld = 1;
                        4'h4: begin ld = 1; ps = 1; m_sp++; end
                        4'h5: begin ld = 1; pp = 1; m_sp--; end
                        4'h6: ld = !eq_i;
                        4'h7: ld = carry_i;
                        default: ld = 0;
                    endcase
                    inc = !ld;
                end
            end
            2: begin
                if (op == 4'hD) begin
                    ms = (m_wait == 0);
                    if (done_i) nxt = 3;
                    else if (m_wait + 1 >= TIMEOUT) nxt = 5;
                end else begin
                    acc = 1; inc = 1; nxt = 0;
                end
            end
            3: begin inc = 1; nxt = 0; end
            4: if (run_i) nxt = 0;
            default: nxt = 5;
        endcase
        x.st      = 7'((1 << nxt) & 0) | {m_phase == 5, 6'(1 << m_phase)};
        x.strobes = {wr, ld, inc, acc, ps, pp, ms};
        x.dec     = {is_ext, op == 4'hD, op == 4'hE, op == 4'h5, op == 4'h7, op == 4'h5};
        x.sp      = 3'(rst ? m_sp - (ps ? 1 : 0) + (pp ? 1 : 0) : m_sp - (ps ? 1 : 0) + (pp ? 1 : 0));
        exp_q.push_back(x);
        m_wait = (m_phase == 2 && nxt == 2) ? m_wait + 1 : 0;
        m_phase = nxt;
        if (rst) begin m_phase = 0; m_sp = 0; m_wait = 0; end
        @(posedge clk); #1;
    endtask

    // Runs one instruction from FETCH until the sequencer settles again.
    task automatic issueOp(input logic [3:0] op, input bit eq_i, input bit carry_i,
                           input int mul_delay);
        int  n = 0;
        bit  d;
        do begin
            d = (m_phase == 2) ? (m_wait == mul_delay - 1) : ($urandom_range(0, 3) == 0);
            applyStimulus(0, 0, op, eq_i, carry_i, d);
            n++;
        end while (!(m_phase == 0 || m_phase == 4 || m_phase == 5) && n < 40);
    endtask

    task automatic checkOutput(input exp_t x);
        logic [6:0] a_st;
        logic [6:0] a_str;
        logic [5:0] a_dec;
        a_st  = {fault, state};
        a_str = {WrEn, pc_load, pc_inc, acc_load, push, pop, mul_start};
        a_dec = {e, m, data_mux, load_mux, jump_mux};
        checks++;
        if (a_st !== x.st) begin
            errors++;
            $display("[TB] FAIL state cycle %0d: got %b expected %b", cycle_no, a_st, x.st);
        end
        checks++;
        if (a_str !== x.strobes) begin
            errors++;
            $display("[TB] FAIL strobes cycle %0d: got %b expected %b", cycle_no, a_str, x.strobes);
        end
        checks++;
        if (a_dec !== x.dec) begin
            errors++;
            $display("[TB] FAIL decode cycle %0d: got %b expected %b", cycle_no, a_dec, x.dec);
        end
        checks++;
        if (sp !== x.sp) begin
            errors++;
            $display("[TB] FAIL sp cycle %0d: got %0d expected %0d", cycle_no, sp, x.sp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
            cycle_no++;
        end
    end

    initial begin
        logic [3:0] op;
        reset = 1; run = 0; inst = 4'h0; eq = 0; carry = 0; mul_done = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 0, 4'h0, 0, 0, 0);

        $display("[TB] LDA sequence");
        issueOp(4'h3, 0, 0, 0);

        $display("[TB] JMS until stack overflow");
        repeat (5) issueOp(4'h4, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 4'h4, 0, 0, 1);
        applyStimulus(1, 0, 4'h4, 0, 0, 0);

        $display("[TB] BBL with empty stack");
        issueOp(4'h5, 0, 0, 0);
        applyStimulus(1, 0, 4'h5, 0, 0, 0);
        applyStimulus(0, 0, 4'h0, 0, 0, 0);
        applyStimulus(1, 0, 4'h0, 0, 0, 0);

        $display("[TB] MUL handshake and timeout");
        issueOp(4'hD, 0, 0, 3);
        issueOp(4'hD, 0, 0, TIMEOUT);
        issueOp(4'hD, 0, 0, 0);
        applyStimulus(1, 0, 4'hD, 0, 0, 0);

        $display("[TB] conditional jumps");
        issueOp(4'h6, 0, 0, 0);
        issueOp(4'h6, 1, 0, 0);
        issueOp(4'h7, 0, 1, 0);
        issueOp(4'h7, 0, 0, 0);
        issueOp(4'h0, 0, 0, 0);

        $display("[TB] STP halt and resume");
        issueOp(4'h2, 0, 0, 0);
        repeat (10) applyStimulus(0, 0, 4'h2, 1, 1, 1);
        applyStimulus(0, 1, 4'h2, 0, 0, 0);

        $display("[TB] reset during multiplier wait");
        applyStimulus(0, 0, 4'hD, 0, 0, 0);
        applyStimulus(0, 0, 4'hD, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 4'hD, 0, 0, 0);
        applyStimulus(1, 0, 4'hD, 0, 0, 0);
        applyStimulus(0, 0, 4'h9, 0, 0, 0);
        applyStimulus(0, 0, 4'h9, 0, 0, 0);

        $display("[TB] randomized instruction stream");
        for (int i = 0; i < 250; i++) begin
            if (m_phase == 5) begin
                applyStimulus(1, 0, inst, 0, 0, 0);
            end else if (m_phase == 4) begin
                applyStimulus(0, $urandom_range(0, 3) == 0, inst, 0, 0, 0);
            end else begin
                op = 4'($urandom_range(0, 15));
                issueOp(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(1, TIMEOUT + 1));
            end
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
